// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: opcodes, FSM state encoding,
// iteration count and small operand helpers.
package div_sequencer_pkg;

  // Divide/remainder opcodes; any other encoding is treated as illegal.
  typedef enum logic [2:0] {
    OP_DIV  = 3'd0,
    OP_DIVU = 3'd1,
    OP_MOD  = 3'd2,
    OP_MODU = 3'd3
  } opcode_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // One quotient bit per ITER cycle.
  localparam int DIV_ITERS = 32;

  // Signed opcodes take operand magnitudes and fix up signs afterwards.
  function automatic logic is_signed_op(input opcode_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Two's-complement magnitude (modulo 2^32) when the operand is signed.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract step. The next dividend bit is taken
// from the MSB of the quotient register, which shifts left as quotient bits
// are produced.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] rem_shift;
  logic [32:0] diff;

  // Trial subtract; a borrow in bit 32 means restore the shifted remainder.
  always_comb begin
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {1'b0, dvs};
    if (diff[32]) begin
      rem_next = rem_shift[31:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit divide/remainder sequencer.
// Flow: IDLE -> PREP -> ITER (32 cycles) -> FIX -> DONE.
// Optional macro DIV_EARLY_OUT_EN: PREP jumps straight to FIX when the divisor
// is zero or |dividend| < |divisor|.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side accepts only in IDLE with flush low; once
// resp_valid rises, resp_result/resp_dest hold until resp_ready is seen.
// flush or reset abandons any operation and returns to IDLE.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  opcode_t     req_opcode,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [4:0]  req_dest,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_dest,
  output div_state_t  dbg_state
);

  div_state_t  state_q, state_d;
  logic        accept;
  logic [5:0]  cnt_q;
  opcode_t     op_q;
  logic [31:0] src1_q, src2_q;
  logic [4:0]  dest_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        q_neg_q, r_neg_q;
  logic [31:0] result_q;

  logic        sgn;
  logic [31:0] mag1, mag2;
  logic        early_out;
  logic [31:0] rem_next, quo_next;
  logic [31:0] q_fix, r_fix, fix_result;

  assign req_ready   = (state_q == IDLE) && !reset;
  assign resp_valid  = (state_q == DONE) && !reset;
  assign resp_result = reset ? 32'd0 : result_q;
  assign resp_dest   = reset ? 5'd0 : dest_q;
  assign dbg_state   = reset ? IDLE : state_q;
  assign accept      = req_valid && req_ready && !flush;

  // Operand magnitudes and early-out decision, used during PREP.
  assign sgn  = is_signed_op(op_q);
  assign mag1 = magnitude(src1_q, sgn);
  assign mag2 = magnitude(src2_q, sgn);
`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag2 == 32'd0) || (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign fix-up, divide-by-zero override and result selection for FIX.
  always_comb begin
    q_fix = q_neg_q ? (32'd0 - quo_q) : quo_q;
    r_fix = r_neg_q ? (32'd0 - rem_q) : rem_q;
    if (src2_q == 32'd0) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = src1_q;
    end
    case (op_q)
      OP_DIV, OP_DIVU: fix_result = q_fix;
      OP_MOD, OP_MODU: fix_result = r_fix;
      default:         fix_result = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PREP;
      PREP:    state_d = early_out ? FIX : ITER;
      ITER:    if (cnt_q == 6'(DIV_ITERS - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath: latch request, prepare magnitudes, iterate, then fix up.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 6'd0;
      op_q     <= OP_DIV;
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      dest_q   <= 5'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvs_q    <= 32'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= req_opcode;
            src1_q <= req_src1;
            src2_q <= req_src2;
            dest_q <= req_dest;
          end
        end
        PREP: begin
          quo_q   <= early_out ? 32'd0 : mag1;
          rem_q   <= early_out ? mag1 : 32'd0;
          dvs_q   <= mag2;
          q_neg_q <= sgn && (src1_q[31] ^ src2_q[31]);
          r_neg_q <= sgn && src1_q[31];
          cnt_q   <= 6'd0;
        end
        ITER: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          result_q <= fix_result;
          cnt_q    <= 6'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
